// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one combinational 32-bit ALU between two
// requesters. Round-robin grant, at most one operation per cycle, and a
// registered valid/ready response per port (result visible the cycle after
// acceptance, at most one outstanding result per port).
//
// Ports:
//   clk, rst                          clock (rising edge), sync active-high reset
//   req_valid/ready/a/b/aluc{0,1}     request handshake + operands + ALU op code
//   rsp_valid/ready/r/z{0,1}          response handshake + result + zero flag
//   idle                              no held results and no pending requests
//   gnt_cnt0/1, conflict_cnt          saturating statistics counters, present
//                                     only when ALU_ARB_STATS_EN is defined
//
// Parameters:
//   RR_INIT  port holding round-robin priority after reset (0 or 1)
//   CNT_W    statistics counter width
//
// Optional build macro: ALU_ARB_STATS_EN

// Combinational ALU. Shift amount comes from a[4:0], shifted value from b.
module alu_share_arb_alu (
  input  logic [3:0]  aluc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] r,
  output logic        z
);
  always_comb begin
    r = '0;
    casez (aluc)
      4'b?000: r = a + b;
      4'b?100: r = a - b;
      4'b?001: r = a & b;
      4'b?101: r = a | b;
      4'b?010: r = a ^ b;
      4'b?110: r = {b[15:0], 16'h0000};
      4'b?011: r = b << a[4:0];
      4'b0111: r = b >> a[4:0];
      4'b1111: r = $unsigned($signed(b) >>> a[4:0]);
      default: r = '0;
    endcase
    z = (r == '0);
  end
endmodule

module alu_share_arb #(
  parameter int unsigned RR_INIT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid0,
  output logic        req_ready0,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [3:0]  req_aluc0,
  output logic        rsp_valid0,
  input  logic        rsp_ready0,
  output logic [31:0] rsp_r0,
  output logic        rsp_z0,
  input  logic        req_valid1,
  output logic        req_ready1,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_aluc1,
  output logic        rsp_valid1,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_r1,
  output logic        rsp_z1,
  output logic        idle
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("alu_share_arb: CNT_W must be at least 1");
  end

  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

  localparam pri_t PRI_RESET = (RR_INIT != 0) ? PRI1 : PRI0;

  pri_t        rr_ptr;
  logic        elig0, elig1;
  logic        grant0, grant1;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_a, alu_b, alu_r;
  logic        alu_z;

  // A held result that is consumed this cycle frees its slot for a new one.
  always_comb begin
    elig0  = req_valid0 & (~rsp_valid0 | rsp_ready0);
    elig1  = req_valid1 & (~rsp_valid1 | rsp_ready1);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = (rr_ptr == PRI0);
        grant1 = (rr_ptr == PRI1);
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;
  assign idle = ~rsp_valid0 & ~rsp_valid1 & ~req_valid0 & ~req_valid1;

  // Port 0 drives the ALU whenever port 1 is not granted.
  always_comb begin
    alu_a    = grant1 ? req_a1    : req_a0;
    alu_b    = grant1 ? req_b1    : req_b0;
    alu_aluc = grant1 ? req_aluc1 : req_aluc0;
  end

  alu_share_arb_alu u_alu (
    .aluc (alu_aluc),
    .a    (alu_a),
    .b    (alu_b),
    .r    (alu_r),
    .z    (alu_z)
  );

  // Priority passes to the loser of each grant; it holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PRI_RESET;
    end else if (grant0) begin
      rr_ptr <= PRI1;
    end else if (grant1) begin
      rr_ptr <= PRI0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid0 <= 1'b0;
      rsp_r0     <= '0;
      rsp_z0     <= 1'b0;
    end else if (grant0) begin
      rsp_valid0 <= 1'b1;
      rsp_r0     <= alu_r;
      rsp_z0     <= alu_z;
    end else if (rsp_valid0 && rsp_ready0) begin
      rsp_valid0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid1 <= 1'b0;
      rsp_r1     <= '0;
      rsp_z1     <= 1'b0;
    end else if (grant1) begin
      rsp_valid1 <= 1'b1;
      rsp_r1     <= alu_r;
      rsp_z1     <= alu_z;
    end else if (rsp_valid1 && rsp_ready1) begin
      rsp_valid1 <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (grant1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
      if (elig0 && elig1 && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed steps followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_alu_share_arb;

  localparam int unsigned TB_RR_INIT = 0;
  localparam int unsigned TB_CNT_W   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_aluc0, req_aluc1;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0, rsp_ready1;
  logic [31:0] rsp_r0, rsp_r1;
  logic        rsp_z0, rsp_z1;
  logic        idle;
`ifdef ALU_ARB_STATS_EN
  logic [TB_CNT_W-1:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  always #5 clk = ~clk;

  alu_share_arb #(.RR_INIT(TB_RR_INIT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_ready0(req_ready0), .req_a0(req_a0),
    .req_b0(req_b0), .req_aluc0(req_aluc0), .rsp_valid0(rsp_valid0),
    .rsp_ready0(rsp_ready0), .rsp_r0(rsp_r0), .rsp_z0(rsp_z0),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_a1(req_a1),
    .req_b1(req_b1), .req_aluc1(req_aluc1), .rsp_valid1(rsp_valid1),
    .rsp_ready1(rsp_ready1), .rsp_r1(rsp_r1), .rsp_z1(rsp_z1),
    .idle(idle)
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: one held-result slot per port plus the port that wins a tie.
  bit          m_ok = 1'b0;
  bit          m_rv[2];
  logic [31:0] m_r[2];
  bit          m_z[2];
  int          m_pri;
  bit          m_wait[2];
  int          m_g[2];
  int          m_c;

  logic [3:0] ops[9] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
                         4'b0110, 4'b0011, 4'b0111, 4'b1111};

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sb;
    sh = a % 32;
    sb = b;
    case (op)
      4'b0000: return a + b;
      4'b0100: return a - b;
      4'b0001: return a & b;
      4'b0101: return a | b;
      4'b0010: return a ^ b;
      4'b0110: return b * 32'd65536;
      4'b0011: return b << sh;
      4'b0111: return b >> sh;
      4'b1111: return sb >>> sh;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < (1 << TB_CNT_W) - 1) ? v + 1 : v;
  endfunction

  // One clock cycle: inputs are already driven; check combinational outputs,
  // advance the model, then check registered outputs just after the edge.
  task automatic cycle();
    bit e[2];
    int win;
    bit v[2];
    bit rr[2];
    logic [31:0] res;
    #3;
    v[0] = req_valid0; v[1] = req_valid1;
    rr[0] = rsp_ready0; rr[1] = rsp_ready1;
    for (int i = 0; i < 2; i++) e[i] = v[i] && (!m_rv[i] || rr[i]);
    win = -1;
    if (!rst) begin
      if (e[0] && e[1]) win = m_pri;
      else if (e[0]) win = 0;
      else if (e[1]) win = 1;
    end
    if (m_ok) begin
      check("req_ready0", {31'b0, req_ready0}, {31'b0, win == 0});
      check("req_ready1", {31'b0, req_ready1}, {31'b0, win == 1});
      check("idle", {31'b0, idle},
            {31'b0, !m_rv[0] && !m_rv[1] && !v[0] && !v[1]});
      if (!rst && m_wait[0] && e[0]) check("no_starve0", {31'b0, req_ready0}, 32'd1);
      if (!rst && m_wait[1] && e[1]) check("no_starve1", {31'b0, req_ready1}, 32'd1);
    end
    if (rst) begin
      m_ok = 1'b1;
      m_pri = TB_RR_INIT;
      m_g[0] = 0; m_g[1] = 0; m_c = 0;
      for (int i = 0; i < 2; i++) begin
        m_rv[i] = 1'b0; m_r[i] = 32'h0; m_z[i] = 1'b0; m_wait[i] = 1'b0;
      end
    end else begin
      if (e[0] && e[1]) m_c = sat_inc(m_c);
      for (int i = 0; i < 2; i++) begin
        m_wait[i] = e[i] && (win != i);
        if (win == i) begin
          res = (i == 0) ? alu_ref(req_aluc0, req_a0, req_b0)
                         : alu_ref(req_aluc1, req_a1, req_b1);
          m_rv[i] = 1'b1; m_r[i] = res; m_z[i] = (res == 32'h0);
          m_g[i] = sat_inc(m_g[i]);
        end else if (m_rv[i] && rr[i]) begin
          m_rv[i] = 1'b0;
        end
      end
      if (win >= 0) m_pri = 1 - win;
    end
    @(posedge clk);
    #1;
    check("rsp_valid0", {31'b0, rsp_valid0}, {31'b0, m_rv[0]});
    check("rsp_valid1", {31'b0, rsp_valid1}, {31'b0, m_rv[1]});
    check("rsp_r0", rsp_r0, m_r[0]);
    check("rsp_r1", rsp_r1, m_r[1]);
    check("rsp_z0", {31'b0, rsp_z0}, {31'b0, m_z[0]});
    check("rsp_z1", {31'b0, rsp_z1}, {31'b0, m_z[1]});
`ifdef ALU_ARB_STATS_EN
    check("gnt_cnt0", 32'(gnt_cnt0), m_g[0]);
    check("gnt_cnt1", 32'(gnt_cnt1), m_g[1]);
    check("conflict_cnt", 32'(conflict_cnt), m_c);
`endif
  endtask

  initial begin
    // Reset held two cycles with a request pending on port 0.
    rst = 1'b1;
    req_valid0 = 1'b1; req_a0 = 32'd5; req_b0 = 32'd7; req_aluc0 = 4'b0000;
    req_valid1 = 1'b0; req_a1 = 32'd0; req_b1 = 32'd0; req_aluc1 = 4'b0000;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    #1;
    cycle();
    cycle();

    // Single add on port 0.
    rst = 1'b0;
    cycle();
    check("add_5_7", rsp_r0, 32'd12);
    req_valid0 = 1'b0;
    cycle();

    // Contention from reset priority: sub 3-3 on port 0, or 0xF0|0x0F on port 1.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid0 = 1'b1; req_a0 = 32'd3; req_b0 = 32'd3; req_aluc0 = 4'b0100;
    req_valid1 = 1'b1; req_a1 = 32'hF0; req_b1 = 32'h0F; req_aluc1 = 4'b0101;
    cycle();
    check("sub_zero_r", rsp_r0, 32'h0);
    check("sub_zero_z", {31'b0, rsp_z0}, 32'd1);
    cycle();
    check("or_ff", rsp_r1, 32'hFF);
    for (int k = 0; k < 4; k++) cycle();

    // Backpressure on port 0 while port 1 streams sra.
    rsp_ready0 = 1'b0;
    req_a1 = 32'd4; req_b1 = 32'h8000_0000; req_aluc1 = 4'b1111;
    for (int k = 0; k < 5; k++) cycle();
    check("sra_result", rsp_r1, 32'hF800_0000);
    rsp_ready0 = 1'b1;
    cycle();

    // Reset in the cycle after a port 0 grant.
    req_valid1 = 1'b0;
    req_a0 = 32'd9; req_b0 = 32'd1; req_aluc0 = 4'b0000;
    cycle();
    rst = 1'b1; req_valid0 = 1'b0;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(99) < 2);
      req_valid0 = ($urandom_range(99) < 70);
      req_valid1 = ($urandom_range(99) < 70);
      rsp_ready0 = ($urandom_range(99) < 60);
      rsp_ready1 = ($urandom_range(99) < 60);
      req_aluc0 = ops[$urandom_range(8)];
      req_aluc1 = ops[$urandom_range(8)];
      req_a0 = $urandom; req_b0 = $urandom;
      req_a1 = $urandom; req_b1 = $urandom;
      if ($urandom_range(3) == 0) req_b0 = req_a0;
      if ($urandom_range(3) == 0) req_b1 = req_a1;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
